seq_alu: RTL

Parametrised, handshaked multi-cycle ALU. It replaces the combinational enable-gated 8-bit ALU in datapaths that need registered results, backpressure, status flags and wider operands. It keeps the same 16-entry opcode map. Single-cycle ops complete in 1 cycle. MUL and DIV run as iterative shift-add and restoring-divide engines of WIDTH cycles. It sits between an operand source (valid/ready) and a result sink (valid/ready).

---
 rtl/seq_alu.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU with registered 2*WIDTH result and status flags
//   clk, rst (async, active-high)
//   in_valid/in_ready + a, b, cmd : command channel, captured on accept
//   out_valid/out_ready + res, zero, carry, dz_err : result channel, held until taken
//   busy : MUL/DIV iterative engine running
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         cmd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               zero,
  output logic               carry,
  output logic               dz_err,
  output logic               busy
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [W2-1:0] ae, be, sres, p, p_n;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0] msum, dshift, ddiff;
  logic [CW-1:0] cnt;
  logic scarry, sdz, accept, multi, last, is_div;
  assign ae = {{WIDTH{1'b0}}, a};
  assign be = {{WIDTH{1'b0}}, b};
  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign busy = state == BUSY;
  assign accept = in_valid && in_ready;
  // MUL/DIV by zero resolve in one cycle; only nonzero divisors/multipliers iterate
  assign multi = (cmd == 4'd10 || cmd == 4'd13) && b != '0;
  assign last = cnt == CW'(WIDTH - 1);
  // p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign msum = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
  assign dshift = {p[W2-1:WIDTH], p[WIDTH-1]};
  assign ddiff = dshift - {1'b0, opnd};
  assign p_n = !is_div ? {msum, p[WIDTH-1:1]} :
               ddiff[WIDTH] ? {dshift[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
                              {ddiff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  always_comb begin
    sres = '0;
    scarry = 1'b0;
    sdz = 1'b0;
    case (cmd)
      4'd0: begin sres = ae + be; scarry = sres[WIDTH]; end
      4'd1: begin sres = ae - be; scarry = a < b; end
      4'd2: sres = ae & be;
      4'd3: sres = ae | be;
      4'd4: sres = ae ^ be;
      4'd5: sres = {{WIDTH{1'b0}}, ~(a | b)};
      4'd6: sres = {{WIDTH{1'b0}}, ~(a & b)};
      4'd7: sres = {{WIDTH{1'b0}}, ~(a ^ b)};
      4'd8: sres = ae << b;
      4'd9: sres = ae >> b;
      4'd10: begin sres = {a, {WIDTH{1'b1}}}; sdz = 1'b1; end
      4'd11: sres = ae + W2'(1);
      4'd12: begin sres = ae - W2'(1); scarry = a == '0; end
      4'd13: sres = '0;
      4'd14: sres = ae;
      default: sres = {{WIDTH{1'b0}}, ~a};
    endcase
  end
  always_comb begin
    state_n = accept ? (multi ? BUSY : DONE) :
              (state == BUSY && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      dz_err <= 1'b0;
      p <= '0;
      opnd <= '0;
      cnt <= '0;
      is_div <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        is_div <= cmd == 4'd10;
        opnd <= cmd == 4'd10 ? b : a;
        p <= cmd == 4'd10 ? ae : be;
        cnt <= '0;
        if (!multi) begin
          res <= sres;
          zero <= sres == '0;
          carry <= scarry;
          dz_err <= sdz;
        end
      end else if (state == BUSY) begin
        p <= p_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          res <= p_n;
          zero <= p_n == '0;
          carry <= 1'b0;
          dz_err <= 1'b0;
        end
      end
    end
  end
endmodule
